// File: rtl/user_tag_tracker.sv
// Tracks outstanding non-posted read tags: allocation, completion retire,
// per-tag age timeout and unexpected-completion flagging.
module user_tag_tracker #(
  parameter int NUM_TAGS       = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       user_clk,
  input  logic       reset,
  output logic       alloc_valid,
  output logic [7:0] alloc_tag,
  input  logic       alloc_ready,
  input  logic       cpl_valid,
  input  logic [7:0] cpl_tag,
  input  logic       cpl_last,
  output logic       timeout_valid,
  output logic [7:0] timeout_tag,
  output logic       err_unexpected,
  output logic [4:0] outstanding_cnt,
  output logic       tags_full,
  output logic       tags_idle
);

  // Expired is raised on the edge where age steps to TIMEOUT_CYCLES-1.
  localparam logic [15:0] AGE_PRE = 16'(TIMEOUT_CYCLES - 2);

  logic [NUM_TAGS-1:0] busy;
  logic [NUM_TAGS-1:0] expired;
  logic [15:0]         age [NUM_TAGS];

  logic [NUM_TAGS-1:0] alloc_hit;
  logic [NUM_TAGS-1:0] cpl_hit;
  logic [NUM_TAGS-1:0] to_hit;
  logic                free_any;
  logic [7:0]          free_tag;
  logic                to_any;
  logic [7:0]          to_tag;
  logic                cpl_err;
  logic [4:0]          cnt;

  always_comb begin
    free_any = 1'b0;
    free_tag = 8'd0;
    to_any   = 1'b0;
    to_tag   = 8'd0;
    cnt      = 5'd0;
    cpl_hit  = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      cpl_hit[i] = cpl_valid && busy[i] && (cpl_tag == 8'(i));
      cnt        = cnt + 5'(busy[i]);
    end
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_any = 1'b1;
        free_tag = 8'(i);
      end
      if (expired[i] && !cpl_hit[i]) begin
        to_any = 1'b1;
        to_tag = 8'(i);
      end
    end
    cpl_err   = cpl_valid && !(|cpl_hit);
    alloc_hit = '0;
    to_hit    = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      alloc_hit[i] = free_any && alloc_ready && (free_tag == 8'(i));
      to_hit[i]    = to_any && (to_tag == 8'(i));
    end
  end

  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) begin
      busy           <= '0;
      expired        <= '0;
      timeout_valid  <= 1'b0;
      timeout_tag    <= 8'd0;
      err_unexpected <= 1'b0;
      for (int i = 0; i < NUM_TAGS; i++) age[i] <= 16'd0;
    end else begin
      timeout_valid  <= to_any;
      timeout_tag    <= to_tag;
      err_unexpected <= cpl_err;
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (alloc_hit[i]) begin
          busy[i]    <= 1'b1;
          expired[i] <= 1'b0;
          age[i]     <= 16'd0;
        end else if (cpl_hit[i]) begin
          expired[i] <= 1'b0;
          if (cpl_last) busy[i] <= 1'b0;
          else          age[i]  <= 16'd0;
        end else if (to_hit[i]) begin
          busy[i]    <= 1'b0;
          expired[i] <= 1'b0;
        end else if (busy[i] && !expired[i]) begin
          age[i] <= age[i] + 16'd1;
          if (age[i] == AGE_PRE) expired[i] <= 1'b1;
        end
      end
    end
  end

  assign alloc_valid     = free_any;
  assign alloc_tag       = free_tag;
  assign tags_full       = !free_any;
  assign tags_idle       = !(|busy);
  assign outstanding_cnt = cnt;

endmodule

// File: tb/tb_user_tag_tracker.sv
// Directed bench for user_tag_tracker with a timeout/error scoreboard.
module tb_user_tag_tracker;

  logic       user_clk = 1'b0;
  logic       reset    = 1'b0;
  logic       alloc_valid;
  logic [7:0] alloc_tag;
  logic       alloc_ready = 1'b0;
  logic       cpl_valid   = 1'b0;
  logic [7:0] cpl_tag     = 8'd0;
  logic       cpl_last    = 1'b0;
  logic       timeout_valid;
  logic [7:0] timeout_tag;
  logic       err_unexpected;
  logic [4:0] outstanding_cnt;
  logic       tags_full;
  logic       tags_idle;

  user_tag_tracker #(.NUM_TAGS(8), .TIMEOUT_CYCLES(20)) dut (
    .user_clk(user_clk),
    .reset(reset),
    .alloc_valid(alloc_valid),
    .alloc_tag(alloc_tag),
    .alloc_ready(alloc_ready),
    .cpl_valid(cpl_valid),
    .cpl_tag(cpl_tag),
    .cpl_last(cpl_last),
    .timeout_valid(timeout_valid),
    .timeout_tag(timeout_tag),
    .err_unexpected(err_unexpected),
    .outstanding_cnt(outstanding_cnt),
    .tags_full(tags_full),
    .tags_idle(tags_idle)
  );

  always #5 user_clk = ~user_clk;

  typedef struct { int tag; int cyc; } exp_t;
  exp_t to_q[$];
  int   err_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  task automatic chk(input string name, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge user_clk);
    #1;
    cyc++;
    if (to_q.size() > 0 && to_q[0].cyc < cyc) begin
      chk("timeout_missed_cyc", cyc, to_q[0].cyc);
      void'(to_q.pop_front());
    end
    if (timeout_valid) begin
      if (to_q.size() == 0) begin
        chk("timeout_spurious_tag", int'(timeout_tag), -1);
      end else begin
        e = to_q.pop_front();
        chk("timeout_tag", int'(timeout_tag), e.tag);
        chk("timeout_cyc", cyc, e.cyc);
      end
    end
    if (err_q.size() > 0 && err_q[0] < cyc) begin
      chk("err_missed_cyc", cyc, err_q[0]);
      void'(err_q.pop_front());
    end
    if (err_unexpected) begin
      if (err_q.size() == 0) chk("err_spurious_cyc", cyc, -1);
      else chk("err_cyc", cyc, err_q.pop_front());
    end
  endtask

  task automatic idle_in();
    alloc_ready = 1'b0;
    cpl_valid   = 1'b0;
    cpl_tag     = 8'd0;
    cpl_last    = 1'b0;
  endtask

  task automatic cpl(input int tag, input logic last);
    cpl_valid = 1'b1;
    cpl_tag   = 8'(tag);
    cpl_last  = last;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_alloc_valid"}, int'(alloc_valid), 1);
    chk({pfx, "_alloc_tag"}, int'(alloc_tag), 0);
    chk({pfx, "_timeout_valid"}, int'(timeout_valid), 0);
    chk({pfx, "_timeout_tag"}, int'(timeout_tag), 0);
    chk({pfx, "_err"}, int'(err_unexpected), 0);
    chk({pfx, "_cnt"}, int'(outstanding_cnt), 0);
    chk({pfx, "_full"}, int'(tags_full), 0);
    chk({pfx, "_idle"}, int'(tags_idle), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    #2 reset = 1'b1;
    #1 chk_reset_vals("rst");
    @(posedge user_clk);
    @(posedge user_clk);
    #1 reset = 1'b0;
    cyc = 0;

    // back-to-back fill
    for (int i = 0; i < 8; i++) begin
      chk("fill_valid", int'(alloc_valid), 1);
      chk("fill_tag", int'(alloc_tag), i);
      alloc_ready = 1'b1;
      tick();
    end
    idle_in();
    chk("full_cnt", int'(outstanding_cnt), 8);
    chk("full_flag", int'(tags_full), 1);
    chk("full_valid", int'(alloc_valid), 0);
    alloc_ready = 1'b1;
    cpl(0, 1'b1);
    tick();
    chk("noalloc_when_full_cnt", int'(outstanding_cnt), 7);
    chk("freed_offer_tag", int'(alloc_tag), 0);
    alloc_ready = 1'b0;
    for (int i = 1; i < 8; i++) begin
      cpl(i, 1'b1);
      tick();
    end
    idle_in();
    chk("drain_idle", int'(tags_idle), 1);
    chk("drain_cnt", int'(outstanding_cnt), 0);

    // free of a middle tag
    alloc_ready = 1'b1;
    repeat (3) tick();
    alloc_ready = 1'b0;
    cpl(1, 1'b1);
    tick();
    idle_in();
    chk("mid_free_cnt", int'(outstanding_cnt), 2);
    chk("mid_free_tag", int'(alloc_tag), 1);
    alloc_ready = 1'b1;
    cpl(0, 1'b1);
    tick();
    idle_in();
    chk("swap_cnt", int'(outstanding_cnt), 2);
    chk("swap_tag", int'(alloc_tag), 0);
    cpl(1, 1'b1);
    tick();
    cpl(2, 1'b1);
    tick();
    idle_in();
    chk("swap_idle", int'(tags_idle), 1);

    // unexpected completions
    cpl(5, 1'b1);
    err_q.push_back(cyc + 1);
    tick();
    cpl(8'h20, 1'b0);
    err_q.push_back(cyc + 1);
    tick();
    cpl(8, 1'b1);
    err_q.push_back(cyc + 1);
    tick();
    idle_in();
    tick();
    chk("err_state_cnt", int'(outstanding_cnt), 0);
    chk("err_state_tag", int'(alloc_tag), 0);

    // single timeout
    c = cyc;
    alloc_ready = 1'b1;
    to_q.push_back('{tag: 0, cyc: c + 21});
    tick();
    idle_in();
    repeat (25) tick();
    chk("to1_idle", int'(tags_idle), 1);
    chk("to1_q_empty", to_q.size(), 0);

    // two tags expiring together
    c = cyc;
    alloc_ready = 1'b1;
    tick();
    cpl(0, 1'b0);
    to_q.push_back('{tag: 0, cyc: c + 22});
    to_q.push_back('{tag: 1, cyc: c + 23});
    tick();
    idle_in();
    repeat (25) tick();
    chk("to2_idle", int'(tags_idle), 1);
    chk("to2_q_empty", to_q.size(), 0);

    // completion in the expiry cycle wins
    c = cyc;
    alloc_ready = 1'b1;
    tick();
    idle_in();
    while (cyc < c + 20) tick();
    cpl(0, 1'b1);
    tick();
    idle_in();
    chk("race_idle", int'(tags_idle), 1);
    repeat (5) tick();

    // reset mid-traffic
    alloc_ready = 1'b1;
    repeat (3) tick();
    alloc_ready = 1'b0;
    chk("pre_rst_cnt", int'(outstanding_cnt), 3);
    cpl(3, 1'b1);
    #1 reset = 1'b1;
    #1 chk_reset_vals("mid_rst");
    idle_in();
    repeat (2) tick();
    #1 reset = 1'b0;
    repeat (25) tick();
    chk("post_rst_idle", int'(tags_idle), 1);
    chk("end_to_q", to_q.size(), 0);
    chk("end_err_q", err_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
